// File: rtl/overture_pkg.sv
// Shared encodings for the overture CPU run controller and the CPU wrappers.
// Pure type definitions; no timing or flow-control behaviour of its own.
package overture_pkg;

  typedef enum logic [1:0] {
    OP_RUN   = 2'b00,
    OP_STEP  = 2'b01,
    OP_HALT  = 2'b10,
    OP_RUN_N = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_HOST  = 2'b01,
    CAUSE_BREAK = 2'b10,
    CAUSE_COUNT = 2'b11
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_COUNT = 2'b10
  } run_state_e;

endpackage

// File: rtl/overture_run_ctrl.sv
// Host run/step/halt controller gating the CPU run strobe; state changes one edge after a command fires.
// Backpressure: cmd_ready is high in IDLE for any op, and while running only for HALT.
module overture_run_ctrl
  import overture_pkg::*;
#(
  parameter int CYCLE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [7:0]         cmd_count,
  input  logic               bp_en,
  input  logic [7:0]         bp_addr,
  input  logic [7:0]         cpu_pc,
  output logic               cpu_run,
  output logic               busy,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [CYCLE_W-1:0] cycles
);

  run_state_e         r_state, w_state_nxt;
  logic [7:0]         r_remaining, w_rem_nxt;
  logic [CYCLE_W-1:0] r_cycles, w_cycles_nxt;
  halt_cause_e        r_halt_cause, w_cause_nxt;
  logic               r_bp_skip, w_skip_nxt;
  logic               r_done, w_done_nxt;
  logic               r_busy;

  cmd_op_e w_op;
  logic    w_running, w_fire, w_halt_fire, w_bp_hit, w_run;

  assign w_op        = cmd_op_e'(cmd_op);
  assign w_running   = (r_state != ST_IDLE);
  assign cmd_ready   = !w_running || (w_op == OP_HALT);
  assign w_fire      = cmd_valid && cmd_ready;
  assign w_halt_fire = w_fire && w_running && (w_op == OP_HALT);
  // bp_skip lets a start sitting on the breakpoint PC execute that instruction once.
  assign w_bp_hit    = bp_en && (cpu_pc == bp_addr) && !r_bp_skip;
  assign w_run       = w_running && !w_bp_hit && !w_halt_fire;
  assign cpu_run     = w_run && !reset;

  assign busy       = r_busy;
  assign done       = r_done;
  assign halt_cause = r_halt_cause;
  assign cycles     = r_cycles;

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_remaining;
    w_cycles_nxt = r_cycles;
    w_cause_nxt  = r_halt_cause;
    w_skip_nxt   = r_bp_skip;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fire && (w_op != OP_HALT)) begin
          w_cycles_nxt = '0;
          if (w_op == OP_RUN_N && cmd_count == 8'd0) begin
            w_cause_nxt = CAUSE_COUNT;
            w_done_nxt  = 1'b1;
          end else begin
            w_cause_nxt = CAUSE_NONE;
            w_skip_nxt  = 1'b1;
            if (w_op == OP_RUN) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_COUNT;
              w_rem_nxt   = (w_op == OP_STEP) ? 8'd1 : cmd_count;
            end
          end
        end
      end
      default: begin
        if (w_halt_fire) begin
          w_state_nxt = ST_IDLE;
          w_cause_nxt = CAUSE_HOST;
          w_done_nxt  = 1'b1;
        end else if (w_bp_hit) begin
          w_state_nxt = ST_IDLE;
          w_cause_nxt = CAUSE_BREAK;
          w_done_nxt  = 1'b1;
        end else begin
          if (r_cycles != {CYCLE_W{1'b1}}) w_cycles_nxt = r_cycles + 1'b1;
          w_skip_nxt = 1'b0;
          if (r_state == ST_COUNT) begin
            w_rem_nxt = r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              w_state_nxt = ST_IDLE;
              w_cause_nxt = CAUSE_COUNT;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= 8'd0;
      r_cycles     <= '0;
      r_halt_cause <= CAUSE_NONE;
      r_bp_skip    <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_rem_nxt;
      r_cycles     <= w_cycles_nxt;
      r_halt_cause <= w_cause_nxt;
      r_bp_skip    <= w_skip_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_overture_run_ctrl.sv
// Directed bench for overture_run_ctrl with a PC-incrementing CPU model and a done-event scoreboard.
module tb_overture_run_ctrl;
  import overture_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_count;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  cpu_pc;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic [1:0]  halt_cause;
  logic [15:0] cycles;

  typedef struct {
    logic [1:0]  cause;
    logic [15:0] cyc;
    logic [7:0]  pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_cnt, done_cnt, waited;
  logic pc_load, clr_cnt;
  logic [7:0] pc_load_val;

  overture_run_ctrl #(.CYCLE_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_pc(cpu_pc), .cpu_run(cpu_run), .busy(busy), .done(done),
    .halt_cause(halt_cause), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // CPU model: one instruction (PC+1) per edge with cpu_run high.
  always @(posedge clk) begin
    if (pc_load) cpu_pc <= pc_load_val;
    else if (cpu_run) cpu_pc <= cpu_pc + 8'd1;
    if (clr_cnt) begin
      run_cnt  <= 0;
      done_cnt <= 0;
    end else begin
      if (cpu_run) run_cnt <= run_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic prep(input logic [7:0] pc);
    pc_load = 1'b1; pc_load_val = pc; clr_cnt = 1'b1;
    @(negedge clk);
    pc_load = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [7:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    #1 chk({tag, "_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int w);
    exp_t e;
    w = 0;
    while (!done && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, done, 1);
    end else if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cause"},  halt_cause, e.cause);
      chk({tag, "_cycles"}, cycles, e.cyc);
      chk({tag, "_pc"},     cpu_pc, e.pc);
      chk({tag, "_busy"},   busy, 0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, done, 0);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 8'd0;
    bp_en = 1'b0; bp_addr = 8'd0; pc_load = 1'b1; pc_load_val = 8'd0; clr_cnt = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("rst_cpu_run", cpu_run, 0);
    @(negedge clk);
    reset = 1'b0; pc_load = 1'b0; clr_cnt = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cause", halt_cause, CAUSE_NONE);
    chk("rst_cycles", cycles, 0);

    // Budgeted run of five instructions.
    prep(8'd0);
    sb.push_back('{cause: CAUSE_COUNT, cyc: 16'd5, pc: 8'd5});
    issue("runn5", OP_RUN_N, 8'd5);
    chk("runn5_busy", busy, 1);
    wait_done("runn5", waited);
    chk("runn5_runcnt", run_cnt, 5);
    chk("runn5_donecnt", done_cnt, 1);

    // HALT while idle changes nothing.
    issue("halt_idle", OP_HALT, 8'd0);
    chk("halt_idle_done", done, 0);
    chk("halt_idle_cause", halt_cause, CAUSE_COUNT);
    chk("halt_idle_cycles", cycles, 5);
    chk("halt_idle_busy", busy, 0);

    // Free run into a breakpoint at 0x06.
    prep(8'd0);
    bp_en = 1'b1; bp_addr = 8'h06;
    sb.push_back('{cause: CAUSE_BREAK, cyc: 16'd6, pc: 8'h06});
    issue("bp_run", OP_RUN, 8'd0);
    wait_done("bp_run", waited);

    // Step off the breakpoint address.
    sb.push_back('{cause: CAUSE_COUNT, cyc: 16'd1, pc: 8'h07});
    issue("step", OP_STEP, 8'd0);
    wait_done("step", waited);

    // HALT coincident with a breakpoint hit at 0x0A: host wins, nothing executes.
    bp_addr = 8'h0A;
    prep(8'h07);
    sb.push_back('{cause: CAUSE_HOST, cyc: 16'd3, pc: 8'h0A});
    issue("halt_bp", OP_RUN, 8'd0);
    waited = 0;
    while (cpu_pc != 8'h0A && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("halt_bp_reached", cpu_pc, 8'h0A);
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1 chk("halt_bp_ready", cmd_ready, 1);
    chk("halt_bp_cpu_run", cpu_run, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("halt_bp", waited);
    bp_en = 1'b0;

    // RUN_N with a zero budget completes at once.
    prep(8'h20);
    sb.push_back('{cause: CAUSE_COUNT, cyc: 16'd0, pc: 8'h20});
    issue("runn0", OP_RUN_N, 8'd0);
    wait_done("runn0", waited);
    chk("runn0_latency", waited, 0);
    chk("runn0_runcnt", run_cnt, 0);

    // Long budget interrupted by reset; a RUN while counting is refused.
    prep(8'd0);
    issue("runn200", OP_RUN_N, 8'd200);
    repeat (48) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    #1 chk("busy_run_ready", cmd_ready, 0);
    chk("busy_cpu_run", cpu_run, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1 chk("midrst_cpu_run", cpu_run, 0);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_cycles", cycles, 0);
    chk("midrst_cause", halt_cause, CAUSE_NONE);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle_run", cpu_run, 0);
    chk("midrst_idle_busy", busy, 0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
